sequential_divider: RTL

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

---
 rtl/divider_pkg.sv | 18 +
 rtl/div_step.sv | 29 ++
 rtl/sequential_divider.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared constants and types for the sequential restoring divider.
package divider_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter must hold values 0..WIDTH-1 with one bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract M, restore on underflow.
module div_step
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] m_ext;

  always_comb begin
    shifted = {a, q[WIDTH-1]};
    m_ext   = {1'b0, m};
    if (shifted >= m_ext) begin
      a_next = WIDTH'(shifted - m_ext);
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      a_next = shifted[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sequential_divider.sv
// Unsigned sequential restoring divider, one quotient bit per cycle.
// Divide-by-zero bypasses the iteration loop and reports one cycle after accept.
module sequential_divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, q_r, m_r;
  logic [WIDTH-1:0] a_nx, q_nx, m_nx;
  logic [WIDTH-1:0] a_step, q_step;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             dz_pend, dz_pend_nx;
  logic             busy_nx, done_nx, dbz_nx;
  logic [WIDTH-1:0] quot_nx, rem_nx;

  logic accept_c;
  logic zero_c;
  logic last_c;

  // dz_pend keeps the block busy for the single bypass cycle, so start is ignored then.
  assign accept_c = (state == IDLE) && !dz_pend && start;
  assign zero_c   = (divisor == '0);
  assign last_c   = (state == RUN) && (cnt == CW'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_r),
    .q      (q_r),
    .m      (m_r),
    .a_next (a_step),
    .q_next (q_step)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_c && !zero_c) state_nx = RUN;
      RUN:     if (last_c) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    a_nx       = a_r;
    q_nx       = q_r;
    m_nx       = m_r;
    cnt_nx     = cnt;
    dz_pend_nx = dz_pend;
    busy_nx    = busy;
    done_nx    = 1'b0;
    quot_nx    = quotient;
    rem_nx     = remainder;
    dbz_nx     = div_by_zero;
    case (state)
      IDLE: begin
        if (dz_pend) begin
          // Q still holds the dividend latched at accept.
          quot_nx    = '1;
          rem_nx     = q_r;
          dbz_nx     = 1'b1;
          done_nx    = 1'b1;
          busy_nx    = 1'b0;
          dz_pend_nx = 1'b0;
        end else if (accept_c) begin
          a_nx       = '0;
          q_nx       = dividend;
          m_nx       = divisor;
          cnt_nx     = '0;
          busy_nx    = 1'b1;
          dz_pend_nx = zero_c;
        end
      end
      RUN: begin
        a_nx   = a_step;
        q_nx   = q_step;
        cnt_nx = cnt + CW'(1);
        if (last_c) begin
          quot_nx = q_step;
          rem_nx  = a_step;
          dbz_nx  = 1'b0;
          done_nx = 1'b1;
          busy_nx = 1'b0;
        end
      end
      default: begin
        busy_nx = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= '0;
      q_r         <= '0;
      m_r         <= '0;
      cnt         <= '0;
      dz_pend     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      a_r         <= a_nx;
      q_r         <= q_nx;
      m_r         <= m_nx;
      cnt         <= cnt_nx;
      dz_pend     <= dz_pend_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      quotient    <= quot_nx;
      remainder   <= rem_nx;
      div_by_zero <= dbz_nx;
    end
  end

endmodule
